// File: rtl/vga_timing_gen.sv
`default_nettype none
// =============================================================================
// vga_timing_gen : 640x480@60 raster timing source (DrawX/DrawY, blank, HS/VS,
//                  line/frame pulses, frame counter). Define VGA_SYNC_DELAY_EN
//                  to delay HS/VS by SYNC_DELAY pixel ticks.
// Revision: 1.0
// =============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Decodes are taken from the next counter value so they line up with DrawX/DrawY.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    blank_d       = blank_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_ce) begin
      if (x_q == c_h_last) begin
        x_d = '0;
        if (y_q == c_v_last) begin
          y_d           = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
      blank_d       = (x_d < c_h_vis) && (y_d < c_v_vis);
      hs_d          = !((x_d >= c_hs_start) && (x_d < c_hs_end));
      vs_d          = !((y_d >= c_vs_start) && (y_d < c_vs_end));
      line_start_d  = (x_d == 10'd0);
      frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
  // Bit 0 is the newest sample; the oldest bit drives the pin.
  logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
  logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;

  always_comb begin
    hs_dly_d = hs_dly_q;
    vs_dly_d = vs_dly_q;
    if (pix_ce) begin
      hs_dly_d = (hs_dly_q << 1) | SYNC_DELAY'(hs_q);
      vs_dly_d = (vs_dly_q << 1) | SYNC_DELAY'(vs_q);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_q <= '1;
      vs_dly_q <= '1;
    end else begin
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
    end
  end

  assign hs = hs_dly_q[SYNC_DELAY-1];
  assign vs = vs_dly_q[SYNC_DELAY-1];
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// tb_vga_timing_gen: scoreboard bench driving a full-size and a reduced-size
// vga_timing_gen from one clock/reset/pix_ce.
module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } tim_t;

  typedef struct {
    int          p;
    int          x, y;
    bit          blank, hs, vs, ls, fs;
    logic [15:0] fc;
  } exp_t;

`ifdef VGA_SYNC_DELAY_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  localparam int FT_A = 800 * 525;
  localparam int FT_B = 16 * 13;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_ce = 1'b0;

  logic [9:0]  x_a, y_a, x_b, y_b;
  logic        bl_a, hs_a, vs_a, ls_a, fs_a;
  logic        bl_b, hs_b, vs_b, ls_b, fs_b;
  logic [15:0] fc_a_o, fc_b_o;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .DrawX(x_a), .DrawY(y_a), .blank(bl_a), .hs(hs_a), .vs(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a_o)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .DrawX(x_b), .DrawY(y_b), .blank(bl_b), .hs(hs_b), .vs(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b_o)
  );

  int checks = 0;
  int failures = 0;

  tim_t ta, tb;
  int   p;
  bit   fresh;
  logic [15:0] fc_a, fc_b;
  exp_t qa[$];
  exp_t qb[$];

  // Hand-computed points on the full-size raster (tick count -> x, y, blank).
  int tbl_p  [7] = '{1, 639, 640, 799, 800, 1439, 1600};
  int tbl_x  [7] = '{1, 639, 640, 799, 0,   639,  0};
  int tbl_y  [7] = '{0, 0,   0,   0,   1,   1,    2};
  int tbl_bl [7] = '{1, 1,   0,   0,   1,   1,    1};

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", n, $time, act, exp);
    end
  endtask

  function automatic exp_t model(input tim_t t, input int pp, input bit fr, input logic [15:0] fc);
    exp_t e;
    int ht, vt, q;
    ht = t.hv + t.hf + t.hs + t.hb;
    vt = t.vv + t.vf + t.vs + t.vb;
    e.p = pp;
    e.x = pp % ht;
    e.y = (pp / ht) % vt;
    e.blank = (pp > 0) && (e.x < t.hv) && (e.y < t.vv);
    q = pp - SD;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (q > 0) begin
      e.hs = !(((q % ht) >= t.hv + t.hf) && ((q % ht) < t.hv + t.hf + t.hs));
      e.vs = !((((q / ht) % vt) >= t.vv + t.vf) && (((q / ht) % vt) < t.vv + t.vf + t.vs));
    end
    e.ls = fr && (pp > 0) && (e.x == 0);
    e.fs = e.ls && (e.y == 0);
    e.fc = fc;
    return e;
  endfunction

  task automatic cycle(input bit ce, input bit rn);
    pix_ce  = ce;
    reset_n = rn;
    @(posedge clk);
    if (!rn) begin
      p = 0; fresh = 1'b0; fc_a = '0; fc_b = '0;
    end else if (ce) begin
      p++;
      fresh = 1'b1;
      if (p % FT_A == 0) fc_a++;
      if (p % FT_B == 0) fc_b++;
    end else begin
      fresh = 1'b0;
    end
    qa.push_back(model(ta, p, fresh, fc_a));
    qb.push_back(model(tb, p, fresh, fc_b));
    @(negedge clk);
  endtask

  // Monitor: every cycle the DUTs present a pixel; compare against the scoreboard.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        cmp("A.DrawX", 32'(x_a), 32'(ea.x));
        cmp("A.DrawY", 32'(y_a), 32'(ea.y));
        cmp("A.blank", 32'(bl_a), 32'(ea.blank));
        cmp("A.hs", 32'(hs_a), 32'(ea.hs));
        cmp("A.vs", 32'(vs_a), 32'(ea.vs));
        cmp("A.line_start", 32'(ls_a), 32'(ea.ls));
        cmp("A.frame_start", 32'(fs_a), 32'(ea.fs));
        cmp("A.frame_count", 32'(fc_a_o), 32'(ea.fc));
        cmp("B.DrawX", 32'(x_b), 32'(eb.x));
        cmp("B.DrawY", 32'(y_b), 32'(eb.y));
        cmp("B.blank", 32'(bl_b), 32'(eb.blank));
        cmp("B.hs", 32'(hs_b), 32'(eb.hs));
        cmp("B.vs", 32'(vs_b), 32'(eb.vs));
        cmp("B.line_start", 32'(ls_b), 32'(eb.ls));
        cmp("B.frame_start", 32'(fs_b), 32'(eb.fs));
        cmp("B.frame_count", 32'(fc_b_o), 32'(eb.fc));
        for (int i = 0; i < 7; i++) begin
          if (ea.p == tbl_p[i]) begin
            cmp("A.tbl.DrawX", 32'(x_a), 32'(tbl_x[i]));
            cmp("A.tbl.DrawY", 32'(y_a), 32'(tbl_y[i]));
            cmp("A.tbl.blank", 32'(bl_a), 32'(tbl_bl[i]));
          end
        end
      end
    end
  end

  initial begin
    int n;
    ta = '{640, 16, 96, 48, 480, 10, 2, 33};
    tb = '{8, 2, 3, 3, 6, 2, 2, 3};
    p = 0; fresh = 1'b0; fc_a = '0; fc_b = '0;

    repeat (3) cycle(1'b0, 1'b0);
    // Continuous run: three lines of A, several frames of B.
    repeat (1700) cycle(1'b1, 1'b1);
    // pix_ce 1,0,0 pattern: every pixel held three clocks.
    repeat (300) begin
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
    end

    // Preload B's frame counter mid-frame, then cross the next frame boundary.
    n = 0;
    while ((p % FT_B) != 100 && n < 400) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    if (n >= 400) begin failures++; $display("FAIL preload_wait timeout"); end
    #1 force u_b.frame_count_q = 16'hFFFF;
    fc_b = 16'hFFFF;
    #1 release u_b.frame_count_q;
    repeat (150) cycle(1'b1, 1'b1);

    // Asynchronous reset mid-line at DrawX=300.
    n = 0;
    while ((p % 800) != 300 && n < 1000) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    if (n >= 1000) begin failures++; $display("FAIL reset_wait timeout"); end
    cmp("A.pre_reset.DrawX", 32'(x_a), 32'd300);
    #2 reset_n = 1'b0;
    #1;
    cmp("A.async.DrawX", 32'(x_a), 32'd0);
    cmp("A.async.DrawY", 32'(y_a), 32'd0);
    cmp("A.async.blank", 32'(bl_a), 32'd0);
    cmp("A.async.hs", 32'(hs_a), 32'd1);
    cmp("A.async.vs", 32'(vs_a), 32'd1);
    cmp("A.async.line_start", 32'(ls_a), 32'd0);
    cmp("A.async.frame_start", 32'(fs_a), 32'd0);
    cmp("A.async.frame_count", 32'(fc_a_o), 32'd0);
    cmp("B.async.DrawX", 32'(x_b), 32'd0);
    cmp("B.async.frame_count", 32'(fc_b_o), 32'd0);
    repeat (2) cycle(1'b1, 1'b0);
    repeat (100) cycle(1'b1, 1'b1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
